// File: rtl/multi_rate_tick_gen.sv
// multi_rate_tick_gen
// One shared prescaler makes a base tick. NUM_CH channels divide that base
// tick by a runtime-programmable period. Each channel gives a 1-clk pulse and
// a 50% duty toggle. A global turbo mode divides every period by 2^TURBO_SHIFT.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   enable     1 = prescaler runs; 0 = whole block frozen
//   turbo      1 = shortened periods on all channels
//   restart    per-channel synchronous restart
//   period     channel i period in base ticks, bits [i*PER_W +: PER_W]
//   base_tick  1-clk pulse every BASE_DIV enabled cycles
//   tick       per-channel 1-clk pulse at the end of each period
//   duty50     per-channel level that toggles on every tick
module multi_rate_tick_gen #(
  parameter int unsigned BASE_DIV    = 100_000,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned PER_W       = 16,
  parameter int unsigned TURBO_SHIFT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    turbo,
  input  logic [NUM_CH-1:0]       restart,
  input  logic [NUM_CH*PER_W-1:0] period,
  output logic                    base_tick,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       duty50
);

  localparam int unsigned PCNT_W = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(BASE_DIV - 1);

  logic [PCNT_W-1:0] pcnt;
  logic [PCNT_W-1:0] pcnt_nxt;
  logic              pre_hit_c;

  logic [PER_W-1:0]  cnt      [NUM_CH];
  logic [PER_W-1:0]  cnt_nxt  [NUM_CH];
  logic [PER_W-1:0]  eff_c    [NUM_CH];
  logic [NUM_CH-1:0] tick_nxt;
  logic [NUM_CH-1:0] duty_nxt;

  // Prescaler: wraps at BASE_DIV-1, holds while disabled.
  always_comb begin
    pre_hit_c = enable && (pcnt == PCNT_LAST);
    pcnt_nxt  = pcnt;
    if (pre_hit_c) begin
      pcnt_nxt = '0;
    end else if (enable) begin
      pcnt_nxt = pcnt + PCNT_W'(1);
    end
  end

  // Effective period per channel; turbo result is clamped to at least 1.
  always_comb begin
    logic [PER_W-1:0] per_v;
    logic [PER_W-1:0] shr_v;
    per_v = '0;
    shr_v = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      per_v = period[i*PER_W +: PER_W];
      shr_v = per_v >> TURBO_SHIFT;
      eff_c[i] = per_v;
      if (turbo) begin
        eff_c[i] = (shr_v == '0) ? PER_W'(1) : shr_v;
      end
    end
  end

  // Channel next state. The >= compare lets a shrunk period fire on the next
  // base tick instead of wrapping the counter. eff_c is >= 1 whenever the
  // period is nonzero, so eff_c-1 cannot underflow in that branch.
  always_comb begin
    for (int i = 0; i < int'(NUM_CH); i++) begin
      cnt_nxt[i]  = cnt[i];
      tick_nxt[i] = 1'b0;
      duty_nxt[i] = duty50[i];
      if (restart[i]) begin
        cnt_nxt[i]  = '0;
        duty_nxt[i] = 1'b0;
      end else if (period[i*PER_W +: PER_W] == '0) begin
        cnt_nxt[i] = '0;
      end else if (pre_hit_c) begin
        if (cnt[i] >= (eff_c[i] - PER_W'(1))) begin
          cnt_nxt[i]  = '0;
          tick_nxt[i] = 1'b1;
          duty_nxt[i] = ~duty50[i];
        end else begin
          cnt_nxt[i] = cnt[i] + PER_W'(1);
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt      <= '0;
      base_tick <= 1'b0;
      tick      <= '0;
      duty50    <= '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        cnt[i] <= '0;
      end
    end else begin
      pcnt      <= pcnt_nxt;
      base_tick <= pre_hit_c;
      tick      <= tick_nxt;
      duty50    <= duty_nxt;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_multi_rate_tick_gen.sv
// Bench for multi_rate_tick_gen: table of scenario-1 vectors, hand sequences
// for the multi-cycle corners, then random stimulus against a reference model.
module tb_multi_rate_tick_gen;

  localparam int unsigned BASE_DIV    = 4;
  localparam int unsigned NUM_CH      = 2;
  localparam int unsigned PER_W       = 8;
  localparam int unsigned TURBO_SHIFT = 2;

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic                    enable = 1'b0;
  logic                    turbo = 1'b0;
  logic [NUM_CH-1:0]       restart = '0;
  logic [NUM_CH*PER_W-1:0] period = '0;
  logic                    base_tick;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       duty50;

  multi_rate_tick_gen #(
    .BASE_DIV(BASE_DIV), .NUM_CH(NUM_CH), .PER_W(PER_W), .TURBO_SHIFT(TURBO_SHIFT)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .turbo(turbo),
    .restart(restart), .period(period),
    .base_tick(base_tick), .tick(tick), .duty50(duty50)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: elapsed enabled cycles within the base interval and
  // elapsed base ticks per channel, in plain integers.
  int                m_pre;
  int                m_el [NUM_CH];
  logic              m_base;
  logic [NUM_CH-1:0] m_tick;
  logic [NUM_CH-1:0] m_duty;

  typedef struct {
    logic              en;
    logic [PER_W-1:0]  p0;
    logic              eb;
    logic [NUM_CH-1:0] et;
    logic [NUM_CH-1:0] ed;
  } vec_t;

  vec_t vecs [24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int eff_of(input int p, input logic tb);
    int s;
    if (!tb) return p;
    s = p / (1 << TURBO_SHIFT);
    return (s < 1) ? 1 : s;
  endfunction

  task automatic model_reset();
    m_pre  = 0;
    m_base = 1'b0;
    m_tick = '0;
    m_duty = '0;
    for (int i = 0; i < int'(NUM_CH); i++) m_el[i] = 0;
  endtask

  task automatic model_step();
    bit hit;
    int p;
    int e;
    hit = (enable == 1'b1) && (m_pre == int'(BASE_DIV) - 1);
    if (hit) m_pre = 0;
    else if (enable) m_pre = m_pre + 1;
    m_base = hit;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      p = int'(period[i*PER_W +: PER_W]);
      m_tick[i] = 1'b0;
      if (restart[i]) begin
        m_el[i]   = 0;
        m_duty[i] = 1'b0;
      end else if (p == 0) begin
        m_el[i] = 0;
      end else if (hit) begin
        e = eff_of(p, turbo);
        if (m_el[i] + 1 >= e) begin
          m_el[i]   = 0;
          m_tick[i] = 1'b1;
          m_duty[i] = ~m_duty[i];
        end else begin
          m_el[i] = m_el[i] + 1;
        end
      end
    end
  endtask

  task automatic set_p(input int ch, input int val);
    period[ch*PER_W +: PER_W] = PER_W'(val);
  endtask

  // One clock edge; outputs sampled 1 time unit after it.
  task automatic tick_clk();
    @(posedge clk);
    model_step();
    #1;
    check("model", 32'({base_tick, tick, duty50}), 32'({m_base, m_tick, m_duty}));
  endtask

  task automatic wait_base();
    int n;
    n = 0;
    do begin
      tick_clk();
      n++;
    end while (base_tick !== 1'b1 && n < 2 * int'(BASE_DIV));
    check("base_timeout", 32'(base_tick), 32'd1);
  endtask

  task automatic cycles_to_tick0(output int n);
    n = 0;
    do begin
      tick_clk();
      n++;
    end while (tick[0] !== 1'b1 && n < 64);
    check("tick0_timeout", 32'(tick[0]), 32'd1);
  endtask

  task automatic run_table();
    for (int k = 0; k < 24; k++) begin
      enable = vecs[k].en;
      set_p(0, int'(vecs[k].p0));
      tick_clk();
      check("tbl_base", 32'(base_tick), 32'(vecs[k].eb));
      check("tbl_tick", 32'(tick), 32'(vecs[k].et));
      check("tbl_duty", 32'(duty50), 32'(vecs[k].ed));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int n1;
    int n2;
    int cnt;

    // Scenario 1 expectations: base tick every 4 edges, tick0 every 12,
    // duty50[0] high between the first and second tick0.
    for (int k = 0; k < 24; k++) begin
      int e;
      e = k + 1;
      vecs[k].en = 1'b1;
      vecs[k].p0 = PER_W'(3);
      vecs[k].eb = (e % 4 == 0);
      vecs[k].et = {1'b0, (e % 12 == 0)};
      vecs[k].ed = {1'b0, (e >= 12 && e < 24)};
    end

    // Reset state.
    #2 reset = 1'b1;
    #10;
    check("reset_outputs", 32'({base_tick, tick, duty50}), 32'd0);
    model_reset();
    set_p(0, 3);
    set_p(1, 0);
    @(negedge clk);
    reset = 1'b0;
    run_table();

    // Turbo: period 8 -> eff 2, tick every 8 clk.
    turbo = 1'b1;
    set_p(0, 8);
    cnt = 0;
    for (int k = 0; k < 24; k++) begin
      tick_clk();
      if (tick[0] === 1'b1) cnt++;
    end
    check("turbo8_ticks", 32'(cnt), 32'd3);
    // Turbo: period 3 -> eff clamps to 1, tick on every base tick.
    set_p(0, 3);
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      tick_clk();
      if (tick[0] === 1'b1) cnt++;
    end
    check("turbo3_ticks", 32'(cnt), 32'd3);
    // Turbo toggled mid-count.
    set_p(0, 12);
    for (int k = 0; k < 6; k++) tick_clk();
    turbo = 1'b0;
    for (int k = 0; k < 10; k++) tick_clk();
    turbo = 1'b1;
    for (int k = 0; k < 20; k++) tick_clk();
    turbo = 1'b0;

    // Period shrink 10 -> 2 at count 5 fires on the next base tick.
    set_p(0, 10);
    restart = 2'b01;
    tick_clk();
    restart = '0;
    for (int k = 0; k < 5; k++) wait_base();
    set_p(0, 2);
    wait_base();
    check("shrink_fire", 32'(tick[0]), 32'd1);
    check("idle_ch1_tick", 32'(tick[1]), 32'd0);
    cycles_to_tick0(n);
    check("shrink_period", 32'(n), 32'd8);

    // Restart in the cycle of the terminal base tick.
    set_p(0, 3);
    set_p(1, 2);
    wait_base();
    restart = 2'b01;
    tick_clk();
    restart = '0;
    wait_base();
    wait_base();
    for (int k = 0; k < int'(BASE_DIV) - 1; k++) tick_clk();
    restart = 2'b01;
    tick_clk();
    restart = '0;
    check("rst_term_base", 32'(base_tick), 32'd1);
    check("rst_term_tick", 32'(tick[0]), 32'd0);
    check("rst_term_duty", 32'(duty50[0]), 32'd0);
    cycles_to_tick0(n);
    check("rst_next_tick", 32'(n), 32'd12);

    // Enable low for 10 clk mid-period delays the tick by exactly 10 clk.
    wait_base();
    restart = 2'b01;
    tick_clk();
    restart = '0;
    cycles_to_tick0(n1);
    check("uninterrupted", 32'(n1), 32'd11);
    wait_base();
    restart = 2'b01;
    tick_clk();
    restart = '0;
    tick_clk();
    tick_clk();
    enable = 1'b0;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick_clk();
      if (base_tick === 1'b1 || tick !== '0) cnt++;
    end
    check("frozen_pulses", 32'(cnt), 32'd0);
    enable = 1'b1;
    cycles_to_tick0(n2);
    check("delayed_tick", 32'(n2 + 12), 32'(n1 + 10));

    // Asynchronous reset mid-count, then scenario 1 again.
    set_p(1, 0);
    cycles_to_tick0(n);
    #2 reset = 1'b1;
    #1;
    check("async_reset", 32'({base_tick, tick, duty50}), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    run_table();

    // Random stimulus against the model.
    set_p(1, 5);
    for (int k = 0; k < 600; k++) begin
      enable  = ($urandom_range(7) != 0);
      if ($urandom_range(39) == 0) turbo = ~turbo;
      restart = '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if ($urandom_range(79) == 0) restart[i] = 1'b1;
        if ($urandom_range(49) == 0) set_p(i, int'($urandom_range(20)));
      end
      tick_clk();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
